// File: rtl/da_idct4.sv
// -----------------------------------------------------------------------------
// da_idct4 -- bit-serial distributed-arithmetic 4-point inverse DCT
//
// Takes one vector of four signed DCT coefficients (Y0..Y3) and evaluates the
// four reconstructed samples (x0..x3) in parallel. Each output lane owns a
// 16-entry table holding every partial sum of that lane's Q10 coefficients.
// The tables are addressed by one bit-slice of the latched inputs per cycle,
// starting at the MSB (sign bit) and working down to the LSB. The result is
// scaled back from Q10 with an arithmetic shift (floor) and saturated.
//
// Ports
//   sys_clk    in   rising-edge clock
//   sys_rst_n  in   asynchronous active-low reset
//   in_valid   in   Y0..Y3 carry a vector this cycle
//   in_ready   out  block is idle and will accept a vector on this edge
//   Y0..Y3     in   signed DATA_W-bit DCT coefficients
//   out_valid  out  single-cycle pulse, x0..x3 carry a new result
//   x0..x3     out  signed DATA_W-bit reconstructed samples (held between pulses)
//
// Timing: accept on edge E0, accumulate on E1..E12, register results on E13;
// out_valid is high in the cycle after E13, which is also an idle cycle, so a
// new vector can be taken one cycle per 14.
// -----------------------------------------------------------------------------
module da_idct4 #(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 24
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] Y0,
    input  logic signed [DATA_W-1:0] Y1,
    input  logic signed [DATA_W-1:0] Y2,
    input  logic signed [DATA_W-1:0] Y3,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] x0,
    output logic signed [DATA_W-1:0] x1,
    output logic signed [DATA_W-1:0] x2,
    output logic signed [DATA_W-1:0] x3
);

    // Q10 transform constants
    localparam int COEF_A = 512;   // 0.5
    localparam int COEF_B = 669;   // 0.6533
    localparam int COEF_C = 277;   // 0.2706
    localparam int FRAC   = 10;

    // Table entries never exceed +/-1970, so 12 bits hold them exactly.
    localparam int TAB_W = 12;
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0]        BIT_TOP = CNT_W'(DATA_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Coefficient of input column 'col' in output row 'row'.
    function automatic int coef(input int row, input int col);
        int c;
        case (row * 4 + col)
            0:       c =  COEF_A;
            1:       c =  COEF_B;
            2:       c =  COEF_A;
            3:       c =  COEF_C;
            4:       c =  COEF_A;
            5:       c =  COEF_C;
            6:       c = -COEF_A;
            7:       c = -COEF_B;
            8:       c =  COEF_A;
            9:       c = -COEF_C;
            10:      c = -COEF_A;
            11:      c =  COEF_B;
            12:      c =  COEF_A;
            13:      c = -COEF_B;
            14:      c =  COEF_A;
            15:      c = -COEF_C;
            default: c = 0;
        endcase
        return c;
    endfunction

    // Table entry: address bit 3 selects Y0, bit 0 selects Y3; the entry is
    // the sum of the row's coefficients for every selected input.
    function automatic int tab_entry(input int row, input int idx);
        int s;
        s = 0;
        for (int c = 0; c < 4; c++) begin
            if (((idx >> (3 - c)) & 1) != 0) begin
                s = s + coef(row, c);
            end
        end
        return s;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [CNT_W-1:0]          bit_reg;
    logic signed [DATA_W-1:0]  y_reg [4];
    logic signed [DATA_W-1:0]  y_in  [4];
    logic signed [DATA_W-1:0]  x_out [4];
    logic [3:0]                addr;
    logic                      accept;
    logic                      sign_bit;
    logic                      last_bit;

    assign y_in[0] = Y0;
    assign y_in[1] = Y1;
    assign y_in[2] = Y2;
    assign y_in[3] = Y3;

    assign accept   = (state_reg == ST_IDLE) && in_valid;
    assign sign_bit = (bit_reg == BIT_TOP);
    assign last_bit = (bit_reg == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_reg == ST_IDLE);
    end

    // Result strobe: high in the cycle after the DONE edge only, so it can
    // never be high for two consecutive cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_reg == ST_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Operand latch and bit counter. Inputs are captured only on accept,
    // so the sender may change them freely once in_ready has dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_reg <= BIT_TOP;
            for (int i = 0; i < 4; i++) begin
                y_reg[i] <= '0;
            end
        end else if (accept) begin
            bit_reg <= BIT_TOP;
            for (int i = 0; i < 4; i++) begin
                y_reg[i] <= y_in[i];
            end
        end else if ((state_reg == ST_RUN) && !last_bit) begin
            bit_reg <= bit_reg - 1'b1;
        end
    end

    genvar gi;
    genvar gj;

    // Bit-slice address shared by all four tables: Y0 drives the MSB.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_addr
            assign addr[3-gi] = y_reg[gi][bit_reg];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-output lanes: table, shift-accumulate, scale and saturate.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic signed [TAB_W-1:0]  tab [16];
            logic signed [TAB_W-1:0]  tab_val;
            logic signed [ACC_W-1:0]  tab_ext;
            logic signed [ACC_W-1:0]  acc_reg;
            logic signed [ACC_W-1:0]  shifted;
            logic signed [DATA_W-1:0] x_sat;
            logic signed [DATA_W-1:0] x_reg;

            for (gj = 0; gj < 16; gj++) begin : g_entry
                assign tab[gj] = TAB_W'(tab_entry(gi, gj));
            end

            assign tab_val = tab[addr];
            assign tab_ext = {{(ACC_W - TAB_W){tab_val[TAB_W-1]}}, tab_val};

            // The sign-bit slice carries weight -2^(DATA_W-1), hence the
            // negated first term; later slices double and add.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    acc_reg <= '0;
                    x_reg   <= '0;
                end else begin
                    if (state_reg == ST_RUN) begin
                        if (sign_bit) begin
                            acc_reg <= -tab_ext;
                        end else begin
                            acc_reg <= (acc_reg <<< 1) + tab_ext;
                        end
                    end
                    if (state_reg == ST_DONE) begin
                        x_reg <= x_sat;
                    end
                end
            end

            // Floor division by 1024, then clamp into the output range.
            assign shifted = acc_reg >>> FRAC;

            always_comb begin
                if (shifted > SAT_MAX) begin
                    x_sat = {1'b0, {(DATA_W - 1){1'b1}}};
                end else if (shifted < SAT_MIN) begin
                    x_sat = {1'b1, {(DATA_W - 1){1'b0}}};
                end else begin
                    x_sat = shifted[DATA_W-1:0];
                end
            end

            assign x_out[gi] = x_reg;
        end
    endgenerate

    assign x0 = x_out[0];
    assign x1 = x_out[1];
    assign x2 = x_out[2];
    assign x3 = x_out[3];

endmodule

// File: tb/tb_da_idct4.sv
// -----------------------------------------------------------------------------
// tb_da_idct4 -- self-checking bench for da_idct4.
// Directed vectors with hand-computed results, a long random back-to-back run
// scored against a plain matrix-multiply reference, and a mid-run reset.
// -----------------------------------------------------------------------------
module tb_da_idct4;

    localparam int DW = 12;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] Y0, Y1, Y2, Y3;
    logic signed [DW-1:0] x0, x1, x2, x3;

    int n_vec = 0;
    int n_bad = 0;

    // Reference transform matrix (Q10), rows = outputs, columns = inputs.
    localparam int M [4][4] = '{
        '{512,  669,  512,  277},
        '{512,  277, -512, -669},
        '{512, -277, -512,  669},
        '{512, -669,  512, -277}
    };

    always #5 sys_clk = ~sys_clk;

    da_idct4 #(.DATA_W(DW), .ACC_W(24)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y0        (Y0),
        .Y1        (Y1),
        .Y2        (Y2),
        .Y3        (Y3),
        .out_valid (out_valid),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3)
    );

    // Exact matrix product, floor-scaled from Q10, clamped to 12-bit signed.
    function automatic int ref_x(input int row, input int a, input int b,
                                 input int c, input int d);
        int s;
        s = M[row][0] * a + M[row][1] * b + M[row][2] * c + M[row][3] * d;
        s = s >>> 10;
        if (s > 2047)  s = 2047;
        if (s < -2048) s = -2048;
        return s;
    endfunction

    function automatic int dut_x(input int i);
        case (i)
            0:       return int'(x0);
            1:       return int'(x1);
            2:       return int'(x2);
            default: return int'(x3);
        endcase
    endfunction

    task automatic test_reset();
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        Y0 = '0; Y1 = '0; Y2 = '0; Y3 = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (dut_x(i) !== 0) begin
                n_bad++;
                $display("FAIL reset_x%0d: got %0d required 0", i, dut_x(i));
            end
        end
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        $display("reset: in_ready=%b out_valid=%b x=%0d,%0d,%0d,%0d", in_ready, out_valid, x0, x1, x2, x3);
    endtask

    // Offer one vector while idle, scramble the inputs after accept, and
    // check latency, handshake and all four results.
    task automatic run_vector(input string name, input int a, input int b,
                              input int c, input int d, input int e0,
                              input int e1, input int e2, input int e3);
        int ex [4];
        int lat;
        bit seen;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        Y0 = DW'(a); Y1 = DW'(b); Y2 = DW'(c); Y3 = DW'(d);
        in_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        Y0 = DW'($urandom); Y1 = DW'($urandom); Y2 = DW'($urandom); Y3 = DW'($urandom);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_busy: in_ready=%b required 0", name, in_ready);
        end
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge sys_clk);
            #1;
            lat++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen || lat != 13) begin
            n_bad++;
            $display("FAIL %s_latency: seen=%0d latency=%0d required 13", name, seen, lat);
        end
        if (seen) begin
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s_ready: in_ready=%b required 1 with out_valid", name, in_ready);
            end
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (dut_x(i) !== ex[i]) begin
                    n_bad++;
                    $display("FAIL %s_x%0d: got %0d required %0d", name, i, dut_x(i), ex[i]);
                end
            end
            @(posedge sys_clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_pulse: out_valid=%b required 0 one cycle later", name, out_valid);
            end
        end
        $display("%s: Y=%0d,%0d,%0d,%0d x=%0d,%0d,%0d,%0d latency=%0d",
                 name, a, b, c, d, x0, x1, x2, x3, lat);
    endtask

    task automatic test_directed();
        run_vector("y0_100",   100,    0,    0,    0,    50,   50,   50,   50);
        run_vector("y1_1000",    0, 1000,    0,    0,   653,  270, -271, -654);
        run_vector("all_max", 2047, 2047, 2047, 2047,  2047, -784,  783,  155);
        run_vector("all_min", -2048, -2048, -2048, -2048, -2048, 784, -784, -156);
        run_vector("y0_neg1",   -1,    0,    0,    0,    -1,   -1,   -1,   -1);
    endtask

    // in_valid held high, a fresh random vector every cycle. Only vectors
    // presented while in_ready is high are expected to be processed.
    task automatic test_back_to_back(input int nvec);
        int q [$];
        int accepts = 0;
        int outs = 0;
        int last_acc = -1;
        int limit;
        int a, b, c, d;
        bit prev_ov = 1'b0;
        limit = nvec * 14 + 40;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (accepts >= nvec && q.size() == 0) break;
            if (accepts < nvec) begin
                Y0 = DW'($urandom); Y1 = DW'($urandom); Y2 = DW'($urandom); Y3 = DW'($urandom);
                in_valid = 1'b1;
                if (in_ready === 1'b1) begin
                    a = int'(Y0); b = int'(Y1); c = int'(Y2); d = int'(Y3);
                    for (int r = 0; r < 4; r++) q.push_back(ref_x(r, a, b, c, d));
                    if (last_acc >= 0) begin
                        n_vec++;
                        if (cyc - last_acc != 14) begin
                            n_bad++;
                            $display("FAIL b2b_interval: got %0d cycles required 14", cyc - last_acc);
                        end
                    end
                    last_acc = cyc;
                    accepts++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge sys_clk);
            #1;
            if (out_valid === 1'b1) begin
                if (prev_ov) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL b2b_double_pulse: out_valid high two cycles in a row");
                end
                if (q.size() < 4) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL b2b_spurious: out_valid=1 with %0d results expected", q.size() / 4);
                end else begin
                    outs++;
                    for (int i = 0; i < 4; i++) begin
                        int e;
                        e = q.pop_front();
                        n_vec++;
                        if (dut_x(i) !== e) begin
                            n_bad++;
                            $display("FAIL b2b_x%0d: result %0d got %0d required %0d", i, outs, dut_x(i), e);
                        end
                    end
                    $display("b2b result %0d: x=%0d,%0d,%0d,%0d", outs, x0, x1, x2, x3);
                end
            end
            prev_ov = (out_valid === 1'b1);
        end
        in_valid = 1'b0;
        n_vec++;
        if (outs != nvec || q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results required %0d", outs, nvec);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset_midrun();
        bit pulse = 1'b0;
        Y0 = DW'(300); Y1 = DW'(-500); Y2 = DW'(20); Y3 = DW'(700);
        in_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_ctrl: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (dut_x(i) !== 0) begin
                n_bad++;
                $display("FAIL midrun_x%0d: got %0d required 0", i, dut_x(i));
            end
        end
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge sys_clk);
            #1;
            if (out_valid !== 1'b0) pulse = 1'b1;
        end
        n_vec++;
        if (pulse) begin
            n_bad++;
            $display("FAIL midrun_pulse: out_valid pulsed after aborted run, required none");
        end
        $display("midrun reset: x=%0d,%0d,%0d,%0d pulse=%0d", x0, x1, x2, x3, pulse);
        run_vector("after_rst", 0, 0, -700, 123,
                   ref_x(0, 0, 0, -700, 123), ref_x(1, 0, 0, -700, 123),
                   ref_x(2, 0, 0, -700, 123), ref_x(3, 0, 0, -700, 123));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back(1000);
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/da_idct4.md
# da_idct4

Bit-serial distributed-arithmetic 4-point inverse DCT for the MJPEG decode path. It is the inverse of the forward DA DCT stage. It accepts one vector of four signed 12-bit DCT coefficients and evaluates all four spatial outputs in parallel, using four internal 16-entry coefficient tables addressed by coefficient bit-slices. It sits between dequantisation and the row/column transpose buffer of the IDCT.

## Interface
- DATA_W, 12: coefficient and output width (two's complement); only the default is verified
- ACC_W, 24: accumulator width; must be at least DATA_W+12
- sys_clk  in  1  rising-edge clock
- sys_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  Y0..Y3 valid this cycle
- in_ready  out  1  block can accept a vector; high only in IDLE
- Y0, Y1, Y2, Y3  in  DATA_W each  signed DCT coefficients
- out_valid  out  1  one-cycle pulse; x0..x3 carry a new result
- x0, x1, x2, x3  out  DATA_W each  signed reconstructed samples

## Operation
- Constants are Q10: A=512 (0.5), B=669 (0.6533), C=277 (0.2706).
- Transform:
  - x0 = A·Y0 + B·Y1 + A·Y2 + C·Y3
  - x1 = A·Y0 + C·Y1 − A·Y2 − B·Y3
  - x2 = A·Y0 − C·Y1 − A·Y2 + B·Y3
  - x3 = A·Y0 − B·Y1 + A·Y2 − C·Y3
- Tables T0..T3: 16 entries each, 12-bit signed, combinational.
  - Address = {b0,b1,b2,b3}, where bi is bit k of the latched Yi.
  - Each entry is the row's coefficient sum over the set bits, e.g. T0[4'b1111]=1970 and T3[4'b0100]=−669.
  - All entries lie within ±1970.
- FSM:
  - IDLE: in_ready=1. When in_valid=1, latch Y0..Y3, clear the bit counter to 11, go to RUN.
  - RUN: 12 cycles, bit k = 11 down to 0.
    - k=11 (sign bit): acc_i ← −sign-extend(Ti[addr]).
    - k<11: acc_i ← (acc_i<<1) + sign-extend(Ti[addr]).
    - After k=0, go to DONE.
  - DONE: register x_i = sat(acc_i >>> 10), assert out_valid, return to IDLE.
- Width and rounding rules:
  - Accumulation is exact; the maximum magnitude is 2048·1970 < 2^22.
  - `>>>` is an arithmetic shift, i.e. floor; there is no rounding.
  - sat clamps to [−2048, 2047].
- Outputs hold their last value between pulses.
- in_valid while busy (RUN/DONE): ignored. The vector is not latched, and the sender must hold it until in_ready.
- Y inputs changing during RUN: no effect, because they were latched at accept.

## Timing
- Reset values: in_ready=1, out_valid=0, x0..x3=0. FSM=IDLE, accumulators=0, bit counter=11.
- Reset asserted mid-RUN or mid-DONE aborts immediately with no out_valid pulse. The first acceptance after release occurs on the first edge with in_valid=1.
- Accept edge E0: in_ready falls in the following cycle.
- RUN accumulates on edges E1..E12.
- DONE edge E13 registers x0..x3. In the cycle after E13: out_valid=1, in_ready=1.
- Latency from accept to out_valid: 13 cycles.
- A vector offered while out_valid=1 is accepted on that edge, so out_valid also falls on that edge.
- Back-to-back throughput with in_valid held high: one vector per 14 cycles.
- out_valid is never high for two consecutive cycles.

## Test plan
- Reset, then Y0=100, others 0 → out_valid at accept+13 with x0..x3 = 50, 50, 50, 50; in_ready high in the same cycle.
- Y1=1000, others 0 → x0=653, x1=270, x2=−271, x3=−654 (checks floor on negatives).
- All Y=2047 → x0 saturates to 2047, x3=155. All Y=−2048 → x0=−2048 (saturated), x3=−156.
- in_valid held high with a new vector presented every cycle → accepts exactly every 14 cycles, with one out_valid per accept. Vectors presented while busy are ignored. Results match a software model over 1000 random vectors.
- Assert sys_rst_n low at accept+6, release two cycles later → outputs zero, no out_valid pulse; the next vector computes correctly.
- Y0=−1, others 0 (sign-bit path) → x0..x3 = −1 each (−512 >>> 10).
